// File: rtl/spart_pkg.sv
// Shared SPART definitions: FSM state encoding and the default oversample ratio,
// common to the receiver and the transmitter.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } spart_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit; reset value is a parameter so
// idle-high lines come out of reset already at their idle level.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state uses non-blocking (<=) so both flops sample the old values
    // and the chain really is two stages deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer driven by an oversample enable, with a
// mid-start-bit glitch check and sticky framing/overrun flags.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    input  logic       clr_rda,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic rxs;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    spart_state_e  state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift_reg, shift_n;
    logic [7:0]    data_n;
    logic          rda_n, fe_n, ov_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shift_reg   <= shift_n;
            rx_data     <= data_n;
            rda         <= rda_n;
            framing_err <= fe_n;
            overrun     <= ov_n;
        end
    end

    // NOTE: every signal gets its hold value first, so no path through the case
    // below can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = rx_data;
        rda_n   = rda;
        fe_n    = framing_err;
        ov_n    = overrun;

        // Host clear comes first so a byte completing on the same edge overrides it.
        if (clr_rda) begin
            rda_n = 1'b0;
            fe_n  = 1'b0;
            ov_n  = 1'b0;
        end

        if (enable) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        if (rxs) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = {rxs, shift_reg[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        state_n = IDLE;
                        if (rxs) begin
                            data_n = shift_reg;
                            rda_n  = 1'b1;
                            if (rda && !clr_rda) ov_n = 1'b1;
                        end else begin
                            fe_n = 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: table of whole frames plus hand sequences for
// glitch, same-edge clear, mid-frame reset and enable stall.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rxd;
    logic       clr_rda;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    logic       tick_run = 1'b0;
    logic [1:0] div = 2'd0;

    int tests  = 0;
    int failed = 0;

    typedef enum int {M_PLAIN, M_LAT, M_CLR} mode_e;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        mode_e      mode;
        logic [7:0] exp_data;
        logic       exp_rda;
        logic       exp_fe;
        logic       exp_ov;
        logic       clr_after;
    } vec_t;

    vec_t vecs[7];

    spart_rx #(.OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rxd         (rxd),
        .clr_rda     (clr_rda),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // One enable every 4 clk while tick_run is set; driven on the falling edge.
    initial begin
        enable = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_run) begin
                div    = div + 2'd1;
                enable = (div == 2'd3);
            end else begin
                enable = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_enables(input int n);
        int k = 0;
        int spins = 0;
        while (k < n) begin
            @(posedge clk);
            spins++;
            if (enable) k++;
            if (spins > 100 * n + 1000) begin
                tests++;
                failed++;
                $display("FAIL enable_timeout: got %0d enables expected %0d", k, n);
                return;
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_rda = 1'b1;
        @(negedge clk) clr_rda = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic r,
                             input logic fe, input logic ov);
        check({name, "_rx_data"}, rx_data, d);
        check({name, "_rda"}, 8'(rda), 8'(r));
        check({name, "_framing_err"}, 8'(framing_err), 8'(fe));
        check({name, "_overrun"}, 8'(overrun), 8'(ov));
    endtask

    // Frame = start, 8 data bits LSB first, stop; 16 enables per bit, then an idle gap.
    // Counting enables from the start bit, the stop sample lands on enable 153.
    task automatic send_byte(input logic [7:0] data, input logic stop, input mode_e mode);
        wait_enables(1);
        @(negedge clk) rxd = 1'b0;
        wait_enables(16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rxd = data[i];
            wait_enables(16);
        end
        @(negedge clk) rxd = stop;
        wait_enables(8);
        if (mode == M_LAT) begin
            @(negedge clk);
            check("latency_before_stop_sample_rda", 8'(rda), 8'd0);
        end
        if (mode == M_CLR) begin
            repeat (3) @(posedge clk);
            @(negedge clk) clr_rda = 1'b1;
            @(posedge clk);
            @(negedge clk) clr_rda = 1'b0;
        end else begin
            wait_enables(1);
            @(negedge clk);
        end
        if (mode == M_LAT) check("latency_at_stop_sample_rda", 8'(rda), 8'd1);
        wait_enables(7);
        @(negedge clk) rxd = 1'b1;
        wait_enables(16);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, M_LAT,   8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h55, 1'b0, M_PLAIN, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h11, 1'b1, M_PLAIN, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, M_PLAIN, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'hC3, 1'b1, M_PLAIN, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, M_PLAIN, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, M_PLAIN, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};

        rst     = 1'b1;
        rxd     = 1'b1;
        clr_rda = 1'b0;
        repeat (4) @(negedge clk);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        tick_run = 1'b1;
        wait_enables(4);

        foreach (vecs[i]) begin
            send_byte(vecs[i].data, vecs[i].stop, vecs[i].mode);
            check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rda,
                      vecs[i].exp_fe, vecs[i].exp_ov);
            if (vecs[i].clr_after) begin
                pulse_clr();
                check_out($sformatf("vec%0d_clr", i), vecs[i].exp_data, 1'b0, 1'b0, 1'b0);
            end
        end

        // Start-bit glitch: low for 3 enables only, then a real frame.
        wait_enables(1);
        @(negedge clk) rxd = 1'b0;
        wait_enables(3);
        @(negedge clk) rxd = 1'b1;
        wait_enables(20);
        @(negedge clk);
        check_out("glitch", 8'hFF, 1'b0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1, M_PLAIN);
        check_out("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // Clear pulsed on the completion edge of a second byte: set wins, no overrun.
        send_byte(8'h11, 1'b1, M_PLAIN);
        check_out("first_11", 8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, M_CLR);
        check_out("clr_same_edge", 8'h22, 1'b1, 1'b0, 1'b0);

        // Framing error while data is pending: rda and rx_data untouched.
        send_byte(8'h55, 1'b0, M_PLAIN);
        check_out("fe_with_rda", 8'h22, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of data bit 4 of 0xFF.
        wait_enables(1);
        @(negedge clk) rxd = 1'b0;
        wait_enables(16);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) rxd = 1'b1;
            wait_enables(16);
        end
        wait_enables(8);
        @(negedge clk) rst = 1'b1;
        #1;
        check_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        wait_enables(16);
        @(negedge clk);
        check_out("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'h81, 1'b1, M_PLAIN);
        check_out("after_reset_81", 8'h81, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // Enable stalled for 100 clk in the middle of a frame.
        fork
            send_byte(8'h0F, 1'b1, M_PLAIN);
            begin
                wait_enables(70);
                @(negedge clk) tick_run = 1'b0;
                repeat (100) @(posedge clk);
                @(negedge clk);
                check_out("stall_hold", 8'h81, 1'b0, 1'b0, 1'b0);
                tick_run = 1'b1;
            end
        join
        check_out("after_stall_0F", 8'h0F, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: enable ticks per serial bit period; legal values 8..64.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  input  1  single-clk oversample tick from the baud divisor block, OVERSAMPLE ticks per bit.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port clr_rda  input  1  single-clk pulse on host read of the receive buffer; clears rda, framing_err and overrun.
REQ-007 SHALL have port rx_data  output  8  last good received byte.
REQ-008 SHALL have port rda  output  1  receive data available.
REQ-009 SHALL have port framing_err  output  1  sticky, stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky, good byte completed while rda was already 1.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer reset to 1; all sampling below uses the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, STOP; tick counter of width ceil(log2(OVERSAMPLE)), bit counter 3 bits, 8-bit shift register.
REQ-013 SHALL advance counters and take samples only on clk edges where enable=1; with enable=0 all state holds.
REQ-014 IDLE: on enable with rxs=0, go START, tick counter cleared to 0.
REQ-015 START: on each enable increment tick counter; at the enable on which the counter equals OVERSAMPLE/2-1 (mid start bit), if rxs=1 return IDLE (glitch rejected, no output change), else go DATA with tick and bit counters cleared.
REQ-016 DATA: on the enable on which tick counter equals OVERSAMPLE-1, counter wraps to 0 and rxs is shifted in at MSB (right shift), so bits arrive LSB first; after the 8th sample go STOP.
REQ-017 STOP: on the enable on which tick counter equals OVERSAMPLE-1, sample rxs and go IDLE.
REQ-018 On a stop sample of 1: rx_data <= shift register, rda <= 1; if rda was already 1 and not cleared that cycle, overrun <= 1.
REQ-019 On a stop sample of 0: framing_err <= 1; rx_data, rda unchanged; a held-low line (break) restarts START from IDLE on the next enable.
REQ-020 clr_rda SHALL clear rda, framing_err, overrun on the next edge; if a byte completes on the same edge, the set wins and overrun is not set.
REQ-021 rx_data SHALL change only on good-stop completion; it is never cleared by clr_rda.
REQ-022 Latency: rda rises on the clk edge of the stop-sample enable, i.e. 9.5 bit periods after the start-bit falling edge plus 2-3 clk synchronizer delay.

Reset
REQ-023 rst SHALL force state IDLE, all counters 0, shift register 0x00, synchronizer 1s, rx_data 0x00, rda 0, framing_err 0, overrun 0, immediately and asynchronously.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release reception resumes only at the next falling edge seen in IDLE.

Structure
REQ-025 State encoding (IDLE=0, START=1, DATA=2, STOP=3) and default OVERSAMPLE SHALL reside in the shared spart package for reuse by the transmitter.
REQ-026 The synchronizer SHALL be a separate sub-module sync2 (1-bit, reset value parameterized, here 1); the FSM, counters and flags are in spart_rx.

Verification
REQ-027 enable every 4 clk, send 0xA5 with stop=1 -> rda=1, rx_data=0xA5, framing_err=0, overrun=0; after clr_rda, rda=0, rx_data still 0xA5.
REQ-028 rxd low for 3 enables then high (glitch) -> FSM returns IDLE, rda stays 0; following frame 0x3C received correctly.
REQ-029 send 0x55 with stop=0 -> framing_err=1, rda=0, rx_data keeps prior value; clr_rda clears framing_err.
REQ-030 send 0x11 then 0x22 without clr_rda -> rx_data=0x22, rda=1, overrun=1; clr_rda pulsed on the completion edge of 0x22 -> rda=1, overrun=0.
REQ-031 assert rst during DATA bit 4 of 0xFF -> all outputs 0 at once; after release, next frame 0x81 received as 0x81.
REQ-032 enable held 0 for 100 clk mid-frame -> no state change; resuming ticks completes frame 0x0F correctly.
